dmem_hs: RTL and testbench

- Parametrised data-memory unit for the SimpRisc core; successor to the single-cycle unified memory.
- Adds a valid/ready request channel and a valid/ready response channel.
- Adds configurable wait states, byte enables, and error reporting for misaligned and out-of-range accesses.
- Sits between the core's load/store stage and on-chip data RAM; one transaction outstanding at a time.

---
 rtl/simprisc_pkg.sv | 18 +
 rtl/dmem_ram.sv | 31 +++
 rtl/dmem_hs.sv | 181 ++++++++++++++++++
 tb/tb_dmem_hs.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simprisc_pkg.sv
// simprisc_pkg: shared types and helpers for the SimpRisc data-memory path.
// Holds the dmem FSM state encoding and access-direction constants.
package simprisc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  localparam logic DMEM_RW_READ  = 1'b0;
  localparam logic DMEM_RW_WRITE = 1'b1;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: word array with byte-enable synchronous write and
// combinational read. Contents are not reset.
module dmem_ram
  import simprisc_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  localparam int BE_W  = be_width(DATA_W),
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_hs.sv
// dmem_hs: handshaked data memory with wait states and error reporting.
// Define DMEM_PIPE_EN to accept a new request during the response handshake.
module dmem_hs
  import simprisc_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1,
  localparam int BE_W = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'(BE_W - 1);
  localparam logic [ADDR_W:0] DEPTH_LIM =
    (ADDR_W+1)'(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam dmem_state_e ACC_STATE =
    (WAIT_CYCLES == 0) ? RESP : WAIT;

  dmem_state_e state;
  dmem_state_e state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;

  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic              accept;
  logic              rsp_hs;
  logic              acc_direct;
  logic              acc_fire;
  logic              a_rw;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [BE_W-1:0]   a_be;
  logic [ADDR_W-1:0] word_idx;
  logic              a_err;
  logic              ram_we;
  logic              rd_ok;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    req_ready = 1'b0;
    unique case (state)
      IDLE:    req_ready = 1'b1;
`ifdef DMEM_PIPE_EN
      RESP:    req_ready = rsp_ready;
`endif
      default: req_ready = 1'b0;
    endcase
  end

  // Gate on nreset so a request held through reset cannot touch the RAM.
  assign accept    = nreset & req_valid & req_ready;
  assign rsp_hs    = (state == RESP) & rsp_ready;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  assign acc_direct = accept & (WAIT_CYCLES == 0);
  assign acc_fire   = acc_direct
                    | ((state == WAIT) & (cnt == 4'd0));

  // Zero-wait accesses use the live request, others the latched copy.
  always_comb begin
    a_rw    = lat_rw;
    a_addr  = lat_addr;
    a_wdata = lat_wdata;
    a_be    = lat_be;
    if (acc_direct) begin
      a_rw    = req_rw;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_be    = req_be;
    end
  end

  assign word_idx = a_addr >> OFF_W;
  assign a_err    = (|(a_addr & OFF_MASK))
                  | ({1'b0, word_idx} >= DEPTH_LIM);
  assign ram_we   = acc_fire & (a_rw == DMEM_RW_WRITE) & ~a_err;
  assign rd_ok    = (a_rw == DMEM_RW_READ) & ~a_err;

  dmem_ram #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (a_be),
    .idx   (word_idx[IDX_W-1:0]),
    .wdata (a_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ACC_STATE;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        if (rsp_hs) begin
          state_nxt = IDLE;
          if (accept) begin
            state_nxt = ACC_STATE;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lat_rw    <= DMEM_RW_READ;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (accept) begin
      lat_rw    <= req_rw;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  // A pipelined zero-wait access overrides the clear on handshake.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (acc_fire) begin
      rsp_rdata <= rd_ok ? ram_rdata : '0;
      rsp_err   <= a_err;
    end else if (rsp_hs) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_hs.sv
// tb_dmem_hs: directed bench for dmem_hs at WAIT_CYCLES 2, 3 and 0.
// Back-to-back expectations follow DMEM_PIPE_EN.
module tb_dmem_hs;

`ifdef DMEM_PIPE_EN
  localparam int EXP_TOTAL = 5;
  localparam int EXP_SPAN  = 4;
`else
  localparam int EXP_TOTAL = 8;
  localparam int EXP_SPAN  = 7;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset    [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_rw    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        busy      [3];

  int total  = 0;
  int passed = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_hs #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .DEPTH_WORDS (1024),
      .WAIT_CYCLES (g == 0 ? 2 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clk       (clk),
      .nreset    (nreset[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_rw    (req_rw[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .busy      (busy[g])
    );
  end

  task automatic txn(
    input  int          d,
    input  logic        rw,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [3:0]  be,
    output logic [31:0] rd,
    output logic        er,
    output int          cyc
  );
    int n;
    req_rw[d]    = rw;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_be[d]    = be;
    req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    cyc = 1;
    while (!rsp_valid[d] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!rsp_valid[d]) begin
      total++;
      $display("FAIL txn_timeout dut%0d addr %h: no response", d, a);
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    if (rsp_ready[d]) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    req_valid[2] = 1'b1;
    req_rw[2]    = 1'b0;
    req_addr[2]  = 32'h0;
    req_be[2]    = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({req_ready[0], rsp_valid[0], rsp_err[0], busy[0]} !== 4'b1000
        || rsp_rdata[0] !== 32'h0)
      $display("FAIL reset_state: rdy/val/err/busy=%b%b%b%b rdata=%h want 1000 0",
               req_ready[0], rsp_valid[0], rsp_err[0], busy[0], rsp_rdata[0]);
    else passed++;
    total++;
    if ({rsp_valid[2], busy[2]} !== 2'b00)
      $display("FAIL reset_hold_req: val/busy=%b%b want 00",
               rsp_valid[2], busy[2]);
    else passed++;
    for (int i = 0; i < 3; i++) nreset[i] = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({rsp_valid[2], busy[2]} !== 2'b11)
      $display("FAIL reset_release_accept: val/busy=%b%b want 11",
               rsp_valid[2], busy[2]);
    else passed++;
    total++;
    if ({req_ready[0], busy[0]} !== 2'b10)
      $display("FAIL post_reset_idle: rdy/busy=%b%b want 10",
               req_ready[0], busy[0]);
    else passed++;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rsp_valid[2] !== 1'b0)
      $display("FAIL reset_release_hs: rsp_valid=%b want 0", rsp_valid[2]);
    else passed++;
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic er;
    int cyc;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, cyc);
    total++;
    if (er !== 1'b0 || rd !== 32'h0)
      $display("FAIL wr_resp: err=%b rdata=%h want 0 0", er, rd);
    else passed++;
    total++;
    if (cyc !== 3)
      $display("FAIL wr_latency: got %0d want 3", cyc);
    else passed++;
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
    total++;
    if (er !== 1'b0 || rd !== 32'hDEADBEEF)
      $display("FAIL rd_data: err=%b rdata=%h want 0 deadbeef", er, rd);
    else passed++;
    total++;
    if (cyc !== 3)
      $display("FAIL rd_latency: got %0d want 3", cyc);
    else passed++;
  endtask

  task automatic test_byte_en();
    logic [31:0] rd;
    logic er;
    int cyc;
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, cyc);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, cyc);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, cyc);
    total++;
    if (er !== 1'b0 || rd !== 32'h11BB33DD)
      $display("FAIL be_merge: err=%b rdata=%h want 0 11bb33dd", er, rd);
    else passed++;
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, cyc);
    total++;
    if (er !== 1'b0)
      $display("FAIL be_zero_err: err=%b want 0", er);
    else passed++;
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, cyc);
    total++;
    if (rd !== 32'h11BB33DD)
      $display("FAIL be_zero_noop: rdata=%h want 11bb33dd", rd);
    else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic er;
    int cyc;
    txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, cyc);
    txn(0, 1'b0, 32'h22, 32'h0, 4'h0, rd, er, cyc);
    total++;
    if (er !== 1'b1 || rd !== 32'h0)
      $display("FAIL err_misaligned_rd: err=%b rdata=%h want 1 0", er, rd);
    else passed++;
    txn(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er, cyc);
    total++;
    if (er !== 1'b1 || rd !== 32'h0)
      $display("FAIL err_range_wr: err=%b rdata=%h want 1 0", er, rd);
    else passed++;
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, cyc);
    total++;
    if (er !== 1'b0 || rd !== 32'hCAFEF00D)
      $display("FAIL err_word0_kept: err=%b rdata=%h want 0 cafef00d", er, rd);
    else passed++;
    txn(0, 1'b1, 32'hFFC, 32'h0BADC0DE, 4'hF, rd, er, cyc);
    txn(0, 1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, cyc);
    total++;
    if (er !== 1'b0 || rd !== 32'h0BADC0DE)
      $display("FAIL last_word: err=%b rdata=%h want 0 0badc0de", er, rd);
    else passed++;
    txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, cyc);
    total++;
    if (er !== 1'b1 || rd !== 32'h0)
      $display("FAIL err_range_rd: err=%b rdata=%h want 1 0", er, rd);
    else passed++;
    txn(0, 1'b1, 32'h41, 32'h1, 4'hF, rd, er, cyc);
    total++;
    if (er !== 1'b1)
      $display("FAIL err_misaligned_wr: err=%b want 1", er);
    else passed++;
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready[0] = 1'b0;
    req_rw[0]    = 1'b0;
    req_addr[0]  = 32'h10;
    req_be[0]    = 4'hF;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_addr[0] = 32'h20;
    n = 0;
    while (!rsp_valid[0] && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid[0], rsp_err[0], req_ready[0]} !== 3'b100
          || rsp_rdata[0] !== 32'hDEADBEEF)
        $display("FAIL bp_hold cyc%0d: val/err/rdy=%b%b%b rdata=%h want 100 deadbeef",
                 i, rsp_valid[0], rsp_err[0], req_ready[0], rsp_rdata[0]);
      else passed++;
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    total++;
`ifdef DMEM_PIPE_EN
    if ({rsp_valid[0], req_ready[0], busy[0]} !== 3'b001)
`else
    if ({rsp_valid[0], req_ready[0], busy[0]} !== 3'b010)
`endif
      $display("FAIL bp_after_hs: val/rdy/busy=%b%b%b",
               rsp_valid[0], req_ready[0], busy[0]);
    else passed++;
`ifndef DMEM_PIPE_EN
    @(posedge clk); #1;
`endif
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b0
        || rsp_rdata[0] !== 32'h11BB33DD)
      $display("FAIL bp_second: val=%b err=%b rdata=%h want 1 0 11bb33dd",
               rsp_valid[0], rsp_err[0], rsp_rdata[0]);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    logic er;
    int cyc;
    int n;
    txn(1, 1'b1, 32'h40, 32'hAA, 4'hF, rd, er, cyc);
    total++;
    if (cyc !== 4 || er !== 1'b0)
      $display("FAIL w3_latency: cyc=%0d err=%b want 4 0", cyc, er);
    else passed++;
    req_rw[1]    = 1'b1;
    req_addr[1]  = 32'h40;
    req_wdata[1] = 32'h55;
    req_be[1]    = 4'hF;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    nreset[1] = 1'b0;
    #1;
    total++;
    if ({busy[1], rsp_valid[1], req_ready[1]} !== 3'b001)
      $display("FAIL rst_async: busy/val/rdy=%b%b%b want 001",
               busy[1], rsp_valid[1], req_ready[1]);
    else passed++;
    @(posedge clk); #1;
    nreset[1] = 1'b1;
    n = 0;
    repeat (8) begin
      if (rsp_valid[1]) n++;
      @(posedge clk); #1;
    end
    total++;
    if (n !== 0)
      $display("FAIL rst_no_rsp: saw %0d response cycles want 0", n);
    else passed++;
    txn(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, cyc);
    total++;
    if (er !== 1'b0 || rd !== 32'hAA)
      $display("FAIL rst_old_value: err=%b rdata=%h want 0 000000aa", er, rd);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic er;
    int cyc;
    int got;
    int issued;
    int first_t;
    int last_t;
    logic will_acc;
    logic [31:0] seen [4];
    for (int i = 0; i < 4; i++) begin
      seen[i] = 32'h0;
      txn(2, 1'b1, 32'(i * 4), 32'hA5A50000 + 32'(i), 4'hF, rd, er, cyc);
      total++;
      if (cyc !== 1 || er !== 1'b0)
        $display("FAIL b2b_preload%0d: cyc=%0d err=%b want 1 0", i, cyc, er);
      else passed++;
    end
    got = 0;
    issued = 0;
    first_t = -1;
    last_t = -1;
    req_rw[2]    = 1'b0;
    req_addr[2]  = 32'h0;
    req_valid[2] = 1'b1;
    for (int t = 0; t < 30 && got < 4; t++) begin
      if (rsp_valid[2]) begin
        seen[got] = rsp_rdata[2];
        if (got == 0) first_t = t;
        last_t = t;
        got++;
      end
      will_acc = req_valid[2] & req_ready[2];
      @(posedge clk); #1;
      if (will_acc) begin
        issued++;
        if (issued < 4) req_addr[2] = 32'(issued * 4);
        else req_valid[2] = 1'b0;
      end
    end
    req_valid[2] = 1'b0;
    total++;
    if (got !== 4)
      $display("FAIL b2b_count: got %0d responses want 4", got);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (seen[i] !== 32'hA5A50000 + 32'(i))
        $display("FAIL b2b_data%0d: got %h want %h",
                 i, seen[i], 32'hA5A50000 + 32'(i));
      else passed++;
    end
    total++;
    if (last_t + 1 !== EXP_TOTAL)
      $display("FAIL b2b_total: got %0d cycles want %0d", last_t + 1, EXP_TOTAL);
    else passed++;
    total++;
    if (last_t - first_t + 1 !== EXP_SPAN)
      $display("FAIL b2b_span: got %0d want %0d", last_t - first_t + 1, EXP_SPAN);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      nreset[i]    = 1'b0;
      req_valid[i] = 1'b0;
      req_rw[i]    = 1'b0;
      req_addr[i]  = 32'h0;
      req_wdata[i] = 32'h0;
      req_be[i]    = 4'h0;
      rsp_ready[i] = 1'b1;
    end
    test_reset();
    test_write_read();
    test_byte_en();
    test_errors();
    test_backpressure();
    test_reset_mid_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
